// File: rtl/pong_game.sv
// pong_game
// Pixel consumer that sits directly behind the LCD timing generator. It holds
// the complete Pong game state (two paddles, the ball, both scores and the
// SERVE/PLAY sequencer) and paints every active pixel as RGB565.
//
// The game state advances once per frame. A registered tick pulses on the
// cycle after the last active pixel (col 479, row 271). Only blanking follows
// that pixel, so no visible pixel ever sees a half-updated frame.
//
// Stream semantics: i_data_enable qualifies i_col/i_row in the same cycle.
// There is no back-pressure. o_data_enable qualifies o_red/o_green/o_blue
// exactly one cycle later. RGB is forced to zero whenever the enable is low.
//
// Ports:
//   i_clk          pixel clock, shared with the timing generator
//   i_rst          synchronous, active-high reset
//   i_data_enable  active-area flag from the timing generator
//   i_col, i_row   active column 0..479 / row 0..271 (zero in blanking)
//   i_btn_*        paddle buttons, debounced but asynchronous to i_clk
//   o_data_enable  i_data_enable delayed by one cycle
//   o_red/green/blue  registered RGB565 pixel
//   o_score_l/r    scores, 0..9, saturating
module pong_game #(
  parameter int BALL_SPEED   = 2,   // ball step per frame on each axis (1..7)
  parameter int PAD_SPEED    = 4,   // paddle step per frame
  parameter int PAD_H        = 48,  // paddle height
  parameter int SERVE_FRAMES = 60   // frames the ball waits at centre
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data_enable,
  input  logic [8:0] i_col,
  input  logic [8:0] i_row,
  input  logic       i_btn_l_up,
  input  logic       i_btn_l_dn,
  input  logic       i_btn_r_up,
  input  logic       i_btn_r_dn,
  output logic       o_data_enable,
  output logic [4:0] o_red,
  output logic [5:0] o_green,
  output logic [4:0] o_blue,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  // All geometry comparisons are done on 10 bits so x+8+BALL_SPEED cannot wrap.
  localparam logic [9:0] BS10     = 10'(BALL_SPEED);
  localparam logic [8:0] BS9      = 9'(BALL_SPEED);
  localparam logic [9:0] PS10     = 10'(PAD_SPEED);
  localparam logic [9:0] PH10     = 10'(PAD_H);
  localparam logic [9:0] PAD_MAX  = 10'(272 - PAD_H);
  localparam logic [9:0] BALL_YMX = 10'd264;          // 272 - ball size
  localparam logic [8:0] BALL_X0  = 9'd236;
  localparam logic [8:0] BALL_Y0  = 9'd132;
  localparam logic [8:0] PAD_Y0   = 9'd112;

  typedef enum logic {S_SERVE, S_PLAY} state_t;

  // Button synchronizer, order {l_up, l_dn, r_up, r_dn}.
  logic [3:0] btn_meta, btn_sync;
  logic       tick;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [8:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic             ball_dx_q, ball_dx_d;   // 1 = moving right
  logic             ball_dy_q, ball_dy_d;   // 1 = moving down
  logic [8:0]       pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;

  logic [9:0] bx10, by10, pl10, pr10;
  logic       hit_l, hit_r;

  function automatic logic [8:0] pad_step(input logic [8:0] y, input logic up,
                                          input logic dn);
    logic [9:0] y10;
    y10      = {1'b0, y};
    pad_step = y;
    if (up && !dn)
      pad_step = (y10 < PS10) ? 9'd0 : 9'(y10 - PS10);
    else if (dn && !up)
      pad_step = (y10 + PS10 > PAD_MAX) ? PAD_MAX[8:0] : 9'(y10 + PS10);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      tick     <= 1'b0;
    end else begin
      btn_meta <= {i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn};
      btn_sync <= btn_meta;
      tick     <= i_data_enable && (i_col == 9'd479) && (i_row == 9'd271);
    end
  end

  assign bx10 = {1'b0, ball_x_q};
  assign by10 = {1'b0, ball_y_q};
  assign pl10 = {1'b0, pad_l_q};
  assign pr10 = {1'b0, pad_r_q};

  // Paddle overlap uses the ball and paddle positions from before this tick.
  assign hit_l = (by10 + 10'd8 > pl10) && (by10 < pl10 + PH10);
  assign hit_r = (by10 + 10'd8 > pr10) && (by10 < pr10 + PH10);

  // Game state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_SERVE;
      serve_cnt_q <= '0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      ball_dx_q   <= 1'b1;
      ball_dy_q   <= 1'b1;
      pad_l_q     <= PAD_Y0;
      pad_r_q     <= PAD_Y0;
      score_l_q   <= '0;
      score_r_q   <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_dx_q   <= ball_dx_d;
      ball_dy_q   <= ball_dy_d;
      pad_l_q     <= pad_l_d;
      pad_r_q     <= pad_r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
    end
  end

  // Next-state logic; nothing changes outside the frame tick.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    ball_dx_d   = ball_dx_q;
    ball_dy_d   = ball_dy_q;
    pad_l_d     = pad_l_q;
    pad_r_d     = pad_r_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;

    if (tick) begin
      pad_l_d = pad_step(pad_l_q, btn_sync[3], btn_sync[2]);
      pad_r_d = pad_step(pad_r_q, btn_sync[1], btn_sync[0]);

      if (state_q == S_SERVE) begin
        if (serve_cnt_q == CNT_LAST) begin
          serve_cnt_d = '0;
          state_d     = S_PLAY;
        end else begin
          serve_cnt_d = serve_cnt_q + 1'b1;
        end
      end else begin
        // Vertical first; a recentre below overrides y but keeps this dy.
        if (!ball_dy_q && (by10 < BS10)) begin
          ball_y_d  = 9'd0;
          ball_dy_d = 1'b1;
        end else if (ball_dy_q && (by10 + BS10 > BALL_YMX)) begin
          ball_y_d  = BALL_YMX[8:0];
          ball_dy_d = 1'b0;
        end else begin
          ball_y_d = ball_dy_q ? ball_y_q + BS9 : ball_y_q - BS9;
        end

        if (!ball_dx_q && (bx10 < 10'd16 + BS10)) begin
          if (hit_l) begin
            ball_x_d  = 9'd16;
            ball_dx_d = 1'b1;
          end else begin
            score_r_d = sat_inc(score_r_q);
            ball_x_d  = BALL_X0;
            ball_y_d  = BALL_Y0;
            ball_dx_d = 1'b0;
            state_d   = S_SERVE;
          end
        end else if (ball_dx_q && (bx10 + 10'd8 + BS10 > 10'd464)) begin
          if (hit_r) begin
            ball_x_d  = 9'd456;
            ball_dx_d = 1'b0;
          end else begin
            score_l_d = sat_inc(score_l_q);
            ball_x_d  = BALL_X0;
            ball_y_d  = BALL_Y0;
            ball_dx_d = 1'b1;
            state_d   = S_SERVE;
          end
        end else begin
          ball_x_d = ball_dx_q ? ball_x_q + BS9 : ball_x_q - BS9;
        end
      end
    end
  end

  // Pixel path
  logic [9:0]  col10, row10;
  logic        ball_px, pad_px, net_px;
  logic [15:0] pix_d;

  assign col10 = {1'b0, i_col};
  assign row10 = {1'b0, i_row};

  always_comb begin
    ball_px = (col10 >= bx10) && (col10 < bx10 + 10'd8) &&
              (row10 >= by10) && (row10 < by10 + 10'd8);
    pad_px  = ((i_col >= 9'd8)   && (i_col <= 9'd15) &&
               (row10 >= pl10)   && (row10 < pl10 + PH10)) ||
              ((i_col >= 9'd464) && (i_col <= 9'd471) &&
               (row10 >= pr10)   && (row10 < pr10 + PH10));
    net_px  = ((i_col == 9'd239) || (i_col == 9'd240)) && !i_row[3];
    pix_d   = 16'h0000;
    if (i_data_enable) begin
      if (ball_px || pad_px) pix_d = 16'hFFFF;          // white
      else if (net_px)       pix_d = {5'd15, 6'd31, 5'd15};  // grey
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_enable <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      o_data_enable <= i_data_enable;
      o_red         <= pix_d[15:11];
      o_green       <= pix_d[10:5];
      o_blue        <= pix_d[4:0];
    end
  end

  assign o_score_l = score_l_q;
  assign o_score_r = score_r_q;

endmodule

// File: tb/tb_pong_game.sv
// Testbench for pong_game. A frame is compressed into a single active pixel
// at (479,271) followed by one blanking cycle. Probes are single active
// pixels whose colour is derived by hand from the ball/paddle trajectory.
// Each driven cycle pushes its expected output onto exp_q. The monitor pops
// one entry per cycle and compares it against the registered outputs.
module tb_pong_game;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_data_enable;
  logic [8:0] i_col, i_row;
  logic       i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn;
  logic       o_data_enable;
  logic [4:0] o_red;
  logic [5:0] o_green;
  logic [4:0] o_blue;
  logic [3:0] o_score_l, o_score_r;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] GREY  = 16'h7BEF;
  localparam logic [15:0] BLACK = 16'h0000;

  // Entry: {check_scores, de, score_l, score_r, rgb565}
  logic [25:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [3:0]  exp_sl, exp_sr;

  always #5 i_clk = ~i_clk;

  pong_game dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data_enable (i_data_enable),
    .i_col         (i_col),
    .i_row         (i_row),
    .i_btn_l_up    (i_btn_l_up),
    .i_btn_l_dn    (i_btn_l_dn),
    .i_btn_r_up    (i_btn_r_up),
    .i_btn_r_dn    (i_btn_r_dn),
    .o_data_enable (o_data_enable),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_score_l     (o_score_l),
    .o_score_r     (o_score_r)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic de, input logic [8:0] col,
                       input logic [8:0] row, input logic chk,
                       input logic [15:0] rgb, input string name);
    i_rst = rst; i_data_enable = de; i_col = col; i_row = row;
    @(posedge i_clk);
    exp_q.push_back({chk, de & ~rst, exp_sl, exp_sr, rgb});
    name_q.push_back(name);
    #1;
  endtask

  task automatic probe(input logic [8:0] col, input logic [8:0] row,
                       input logic [15:0] rgb, input string name);
    drive(1'b0, 1'b1, col, row, 1'b1, rgb, name);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 9'd0, 9'd0, 1'b0, BLACK, "idle");
  endtask

  // One game frame: the last active pixel (always black) then one blank cycle.
  task automatic ticks(input int n);
    repeat (n) begin
      drive(1'b0, 1'b1, 9'd479, 9'd271, 1'b0, BLACK, "tick_px");
      drive(1'b0, 1'b0, 9'd0, 9'd0, 1'b0, BLACK, "idle");
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [25:0] mon_e;
  logic [24:0] mon_act, mon_mask;
  string       mon_name;

  always @(negedge i_clk) begin
    if (exp_q.size() != 0) begin
      mon_e    = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {o_data_enable, o_score_l, o_score_r, o_red, o_green, o_blue};
      mon_mask = mon_e[25] ? {25{1'b1}} : {1'b1, 8'h00, 16'hFFFF};
      n_vec++;
      if (((mon_act ^ mon_e[24:0]) & mon_mask) !== 25'd0) begin
        n_bad++;
        $display("FAIL %s @%0t: got de=%b sl=%0d sr=%0d rgb=%h, want de=%b sl=%0d sr=%0d rgb=%h%s",
                 mon_name, $time, mon_act[24], mon_act[23:20], mon_act[19:16],
                 mon_act[15:0], mon_e[24], mon_e[23:20], mon_e[19:16],
                 mon_e[15:0], mon_e[25] ? "" : " (scores not checked)");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    i_btn_l_up = 0; i_btn_l_dn = 0; i_btn_r_up = 0; i_btn_r_dn = 0;
    exp_sl = 4'd0; exp_sr = 4'd0;

    // Reset while the pixel stream is active: outputs forced low.
    drive(1'b1, 1'b1, 9'd236, 9'd132, 1'b1, BLACK, "rst_out");
    drive(1'b1, 1'b1, 9'd237, 9'd132, 1'b1, BLACK, "rst_out");

    // Reset picture: ball at (236,132), paddles at 112, net.
    probe(9'd236, 9'd132, WHITE, "ball_tl");
    probe(9'd243, 9'd139, WHITE, "ball_br");
    probe(9'd235, 9'd132, BLACK, "ball_left");
    probe(9'd236, 9'd131, BLACK, "ball_above");
    probe(9'd244, 9'd132, BLACK, "ball_right");
    probe(9'd239, 9'd133, WHITE, "ball_over_net");
    probe(9'd239, 9'd0,   GREY,  "net_r0");
    probe(9'd240, 9'd20,  GREY,  "net_r20");
    probe(9'd239, 9'd8,   BLACK, "net_gap");
    probe(9'd241, 9'd0,   BLACK, "net_edge");
    probe(9'd10,  9'd112, WHITE, "lpad_top");
    probe(9'd10,  9'd111, BLACK, "lpad_above");
    probe(9'd15,  9'd159, WHITE, "lpad_bot");
    probe(9'd10,  9'd160, BLACK, "lpad_below");
    probe(9'd7,   9'd120, BLACK, "lpad_lcol");
    probe(9'd16,  9'd120, BLACK, "lpad_rcol");
    probe(9'd464, 9'd112, WHITE, "rpad_top");
    probe(9'd471, 9'd159, WHITE, "rpad_bot");
    probe(9'd472, 9'd120, BLACK, "rpad_rcol");
    drive(1'b0, 1'b0, 9'd236, 9'd132, 1'b1, BLACK, "de_low");

    // Serve period with paddle moves. Both left buttons: no move.
    i_btn_l_up = 1; i_btn_l_dn = 1; idle(3);
    ticks(5);
    i_btn_l_up = 0; i_btn_l_dn = 0; idle(3);
    probe(9'd10, 9'd112, WHITE, "lpad_both");
    probe(9'd10, 9'd111, BLACK, "lpad_both_above");

    // Right paddle down 12 frames: 112 -> 160.
    i_btn_r_dn = 1; idle(3);
    ticks(12);
    i_btn_r_dn = 0; idle(3);
    probe(9'd464, 9'd160, WHITE, "rpad_dn_top");
    probe(9'd464, 9'd159, BLACK, "rpad_dn_above");
    probe(9'd471, 9'd207, WHITE, "rpad_dn_bot");
    probe(9'd471, 9'd208, BLACK, "rpad_dn_below");

    ticks(42);                        // 59 serve frames so far
    probe(9'd236, 9'd132, WHITE, "serve59");
    probe(9'd235, 9'd132, BLACK, "serve59_left");

    // Near-miss tick pixels: none of these may count as a frame.
    drive(1'b0, 1'b0, 9'd479, 9'd271, 1'b0, BLACK, "no_tick_de0");
    drive(1'b0, 1'b0, 9'd479, 9'd271, 1'b0, BLACK, "no_tick_de0");
    drive(1'b0, 1'b1, 9'd478, 9'd271, 1'b1, BLACK, "no_tick_col");
    drive(1'b0, 1'b1, 9'd479, 9'd270, 1'b1, BLACK, "no_tick_row");
    idle(2);

    ticks(1);                         // frame 60: still at centre, now PLAY
    probe(9'd236, 9'd132, WHITE, "serve60");
    probe(9'd235, 9'd132, BLACK, "serve60_left");
    ticks(1);                         // play 1: (238,134)
    probe(9'd238, 9'd134, WHITE, "play1");
    probe(9'd237, 9'd134, BLACK, "play1_left");
    probe(9'd238, 9'd133, BLACK, "play1_above");

    ticks(65);                        // play 66: (368,264)
    probe(9'd368, 9'd264, WHITE, "p66");
    probe(9'd368, 9'd263, BLACK, "p66_above");
    ticks(1);                         // play 67: clamp at 264, dy up
    probe(9'd370, 9'd264, WHITE, "p67");
    probe(9'd369, 9'd264, BLACK, "p67_left");
    ticks(1);                         // play 68: (372,262)
    probe(9'd372, 9'd262, WHITE, "p68");
    probe(9'd372, 9'd270, BLACK, "p68_below");

    ticks(42);                        // play 110: (456,178)
    probe(9'd456, 9'd178, WHITE, "p110");
    probe(9'd455, 9'd178, BLACK, "p110_left");
    ticks(1);                         // play 111: right paddle hit
    probe(9'd456, 9'd176, WHITE, "rhit");
    probe(9'd456, 9'd175, BLACK, "rhit_above");
    probe(9'd456, 9'd184, BLACK, "rhit_below");
    ticks(1);                         // play 112: (454,174) going left
    probe(9'd454, 9'd174, WHITE, "p112");
    probe(9'd462, 9'd174, BLACK, "p112_right");

    ticks(87);                        // play 199: (280,0)
    probe(9'd280, 9'd0, WHITE, "p199");
    probe(9'd279, 9'd0, BLACK, "p199_left");
    ticks(1);                         // play 200: top clamp, dy down
    probe(9'd278, 9'd0, WHITE, "p200");
    ticks(1);                         // play 201: (276,2)
    probe(9'd276, 9'd2, WHITE, "p201");
    probe(9'd276, 9'd1, BLACK, "p201_above");

    ticks(130);                       // play 331: (16,262)
    probe(9'd16, 9'd262, WHITE, "p331");
    probe(9'd15, 9'd262, BLACK, "p331_left");
    ticks(1);                         // play 332: left miss, right scores
    exp_sr = 4'd1;
    probe(9'd236, 9'd132, WHITE, "score_r1");
    probe(9'd16,  9'd262, BLACK, "score_r1_old");

    // Each further round: 60 serve + 111 play frames, always a left miss.
    for (int r = 1; r <= 9; r++) begin
      ticks(171);
      exp_sr = (r < 8) ? 4'(r + 1) : 4'd9;
      probe(9'd236, 9'd132, WHITE, "round_centre");
      probe(9'd235, 9'd132, BLACK, "round_left");
    end

    // Left paddle up 30 frames: clamps at 0.
    i_btn_l_up = 1; idle(3);
    ticks(30);
    i_btn_l_up = 0; idle(3);
    probe(9'd10, 9'd0,  WHITE, "lpad_clamp_top");
    probe(9'd10, 9'd47, WHITE, "lpad_clamp_bot");
    probe(9'd10, 9'd48, BLACK, "lpad_clamp_below");
    // Down 16 frames: 0 -> 64.
    i_btn_l_dn = 1; idle(3);
    ticks(16);
    i_btn_l_dn = 0; idle(3);
    probe(9'd10, 9'd64,  WHITE, "lpad64_top");
    probe(9'd10, 9'd63,  BLACK, "lpad64_above");
    probe(9'd10, 9'd111, WHITE, "lpad64_bot");
    probe(9'd10, 9'd112, BLACK, "lpad64_below");

    ticks(14);                        // serve complete
    ticks(110);                       // ball (16,86), moving left, dy down
    probe(9'd16, 9'd86, WHITE, "q110");
    probe(9'd16, 9'd85, BLACK, "q110_above");
    ticks(1);                         // left paddle hit: (16,88), dx right
    probe(9'd16, 9'd88, WHITE, "lhit");
    probe(9'd16, 9'd87, BLACK, "lhit_above");
    ticks(1);
    probe(9'd18, 9'd90, WHITE, "q112");
    probe(9'd17, 9'd90, BLACK, "q112_left");
    ticks(219);                       // ball (456,2), right paddle at 160
    probe(9'd456, 9'd2, WHITE, "q331");
    probe(9'd456, 9'd1, BLACK, "q331_above");
    ticks(1);                         // right miss: left scores
    exp_sl = 4'd1;
    probe(9'd236, 9'd132, WHITE, "score_l1");
    probe(9'd456, 9'd2,   BLACK, "score_l1_old");

    // Reset mid-frame, then the next pixels render the reset state.
    exp_sl = 4'd0; exp_sr = 4'd0;
    drive(1'b1, 1'b1, 9'd10, 9'd64, 1'b1, BLACK, "rst2_out");
    probe(9'd10,  9'd112, WHITE, "rst2_lpad");
    probe(9'd10,  9'd64,  BLACK, "rst2_lpad_old");
    probe(9'd464, 9'd112, WHITE, "rst2_rpad");
    probe(9'd464, 9'd160, BLACK, "rst2_rpad_old");
    probe(9'd236, 9'd132, WHITE, "rst2_ball");

    idle(2);
    @(negedge i_clk);
    @(negedge i_clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game.md
Name: pong_game

Overview:
- Pixel consumer directly downstream of the LCD timing generator.
- Takes data-enable plus active-area column/row (480x272, both zero-clamped in blanking) and holds the Pong game state: two paddles, ball, scores and serve/play FSM.
- Game state advances once per frame.
- Produces registered RGB565 pixel data plus a delayed data-enable for the panel.

Parameters:
BALL_SPEED, 2, ball step in pixels per frame on each axis (1..7)
PAD_SPEED, 4, paddle step in pixels per frame
PAD_H, 48, paddle height in pixels
SERVE_FRAMES, 60, frames the ball is held at centre before play starts

Ports:
i_clk  input  1  pixel clock, same clock as the timing generator
i_rst  input  1  synchronous, active-high reset
i_data_enable  input  1  active-area flag from the timing generator
i_col  input  9  active column 0..479
i_row  input  9  active row 0..271
i_btn_l_up  input  1  left paddle up, debounced, active-high, asynchronous to i_clk
i_btn_l_dn  input  1  left paddle down
i_btn_r_up  input  1  right paddle up
i_btn_r_dn  input  1  right paddle down
o_data_enable  output  1  i_data_enable delayed by 1 cycle
o_red  output  5  pixel red
o_green  output  6  pixel green
o_blue  output  5  pixel blue
o_score_l  output  4  left score, 0..9
o_score_r  output  4  right score, 0..9

Behaviour:
Geometry and button sync:
- Fixed active area 480x272. Ball is 8x8.
- Left paddle occupies cols 8..15; right paddle occupies cols 464..471.
- Paddle y is the top row, range 0..272-PAD_H.
- Buttons pass through a 2-flop synchronizer before use.

Frame tick:
- Single-cycle pulse, registered.
- Asserted the cycle after a cycle with i_data_enable=1, i_col=479, i_row=271.
- All game registers update only on the tick. Blanking follows, so no active pixel sees a partial update.

Reset (i_rst=1 at a clock edge):
- Outputs: o_data_enable=0, RGB=0, scores=0.
- Paddles y=112. Ball (x,y)=(236,132), dx=right, dy=down.
- State=SERVE, serve counter=0, tick=0.
- Reset mid-frame takes effect next edge. Rendering of the remaining pixels uses the reset state.

Paddles, per tick:
- Up only: y -= PAD_SPEED, clamped at 0.
- Down only: y += PAD_SPEED, clamped at 272-PAD_H.
- Both or neither: no move.
- Paddles move in both FSM states.

FSM:
- SERVE: ball drawn at centre, not moving. Counter increments per tick. When counter reaches SERVE_FRAMES-1, on that tick: counter cleared, state becomes PLAY.
- PLAY, each tick, evaluated in this order:
  1. Vertical. If dy=up and y<BALL_SPEED: y=0, dy=down. Else if dy=down and y+BALL_SPEED>264: y=264, dy=up. Else y±=BALL_SPEED.
  2. Horizontal, left. Applies if dx=left and x<16+BALL_SPEED.
     - If ball overlaps the left paddle vertically (y+8>pad_l_y and y<pad_l_y+PAD_H, using pre-move y values): x=16, dx=right.
     - Else the right player scores: ball recentred, dx=left, state=SERVE.
  3. Horizontal, right. Applies if dx=right and x+8+BALL_SPEED>464. Mirror of the left case.
     - Overlap: x=456, dx=left.
     - Else the left player scores: recentre, dx=right, state=SERVE.
  4. Otherwise: x±=BALL_SPEED.
- On recentre, dy is retained.
- Scores saturate at 9; play continues.
- Horizontal and vertical bounces may occur on the same tick.

Pixel path, 1-cycle latency, all registered:
- o_data_enable <= i_data_enable.
- If i_data_enable=0: RGB=0.
- Otherwise, priority order:
  1. Ball pixel: white (31,63,31).
  2. Paddle pixel: white.
  3. Centre net (col 239..240 and row[3]=0): grey (15,31,15).
  4. Else black.

Widths:
- Ball x/y and paddle y are 9-bit.
- All comparisons use 10-bit sums so that x+8+BALL_SPEED cannot wrap.

Test Plan:
1. Reset, then release -> o_data_enable=0 and RGB=0 one cycle after reset; scores 0; pixel (236,132) white; ball stays there for exactly SERVE_FRAMES=60 ticks, and moves to (238,134) on tick 61.
2. Drive de=1, col=479, row=271 for one cycle -> tick high exactly one cycle later, once. Same col/row with de=0 -> no tick.
3. PLAY with dy=up, y=1, BALL_SPEED=2 -> after tick y=0, dy=down. Next tick y=2.
4. PLAY with dx=left, x=17, left paddle y=100, ball y=120 -> x=16, dx=right, scores unchanged.
5. Same as 4 but paddle y=0 -> o_score_r increments 0->1, ball recentred at (236,132), state SERVE, dx=left. Repeat to 9 -> stays 9.
6. Hold i_btn_l_up and i_btn_l_dn together -> left paddle static. Hold up from y=2 -> y=0 after one tick, stays 0. Pixel at col 10, row 0 white; col 10, row 48 black. o_data_enable lags i_data_enable by exactly 1 cycle.
